lfsr_scrambler_p: RTL

Parametrised, registered multi-bit LFSR engine: the next generation of the team's per-cycle Galois scrambler. It holds its own state register and processes BITS_PER_CYC bits per accepted word. Three modes: signature/CRC absorb, additive (self-inverse) scramble, and bypass. It has valid/ready handshakes on input and output, and a seed-load port. It sits in the line datapath between the framer and the serializer, and is used in the receiver as the matching descrambler or checker.

---
 rtl/lfsr_scrambler_p_if.sv | 27 ++
 rtl/lfsr_scrambler_p.sv | 104 ++++++++++
 2 files changed

// File: rtl/lfsr_scrambler_p_if.sv
// Handshake, seed and observation signals for lfsr_scrambler_p.
// The master side drives words and seeds; the slave side is the scrambler.
interface lfsr_scrambler_p_if #(
  parameter int STATE_W      = 70,
  parameter int BITS_PER_CYC = 12
);
  logic                    load;
  logic [STATE_W-1:0]      seed_in;
  logic [1:0]              mode;
  logic                    in_valid;
  logic                    in_ready;
  logic [BITS_PER_CYC-1:0] in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [BITS_PER_CYC-1:0] out_data;
  logic [STATE_W-1:0]      state_out;

  modport master (
    output load, seed_in, mode, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, state_out
  );

  modport slave (
    input  load, seed_in, mode, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, state_out
  );
endinterface

// File: rtl/lfsr_scrambler_p.sv
// lfsr_scrambler_p: registered multi-bit Galois LFSR engine.
// Modes: 00 absorb (signature), 01 additive scramble/descramble, 1x bypass.
// BITS_PER_CYC chained single-bit steps are applied per accepted word,
// in_data[0] first. A single output register stage with valid/ready.
// Optional feature macro: LFSR_SCR_WORDCNT_EN adds the 32-bit word_cnt port.
module lfsr_scrambler_p #(
  parameter int                 STATE_W      = 70,
  parameter int                 BITS_PER_CYC = 12,
  parameter logic [STATE_W-1:0] TAPS         = 70'h8400_0804_4000_0000,
  parameter logic [STATE_W-1:0] SEED         = '0
) (
  input logic               clk,
  input logic               rst,
  lfsr_scrambler_p_if.slave bus
`ifdef LFSR_SCR_WORDCNT_EN
  ,
  output logic [31:0]       word_cnt
`endif
);

  // Bit 0 always takes the feedback term directly, so its tap bit is dropped.
  localparam logic [STATE_W-1:0] TAPS_EFF = {TAPS[STATE_W-1:1], 1'b0};

  logic [STATE_W-1:0]      r_state;
  logic [STATE_W-1:0]      w_state_nxt;
  logic [BITS_PER_CYC-1:0] r_out_data;
  logic [BITS_PER_CYC-1:0] w_out_bits;
  logic                    r_out_valid;
  logic                    w_in_ready;
  logic                    w_accept;
  logic                    w_absorb;
  logic                    w_bypass;

  assign w_absorb   = (bus.mode == 2'b00);
  assign w_bypass   = bus.mode[1];
  assign w_in_ready = !bus.load && (!r_out_valid || bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_ready;

  // Unrolled word step: chain BITS_PER_CYC single-bit Galois steps.
  always_comb begin
    logic [STATE_W-1:0] v_s;
    logic               v_m;
    logic               v_f;
    v_s        = r_state;
    v_m        = 1'b0;
    v_f        = 1'b0;
    w_out_bits = '0;
    for (int i = 0; i < BITS_PER_CYC; i++) begin
      v_m = v_s[STATE_W-1];
      v_f = w_absorb ? bus.in_data[i] : 1'b0;
      w_out_bits[i] = (w_absorb || w_bypass) ? bus.in_data[i]
                                             : (bus.in_data[i] ^ v_m);
      v_s = {v_s[STATE_W-2:0], v_m ^ v_f} ^ (TAPS_EFF & {STATE_W{v_m}});
    end
    w_state_nxt = w_bypass ? r_state : v_s;
  end

  // State register: load wins over an accept; bypass leaves it unchanged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= SEED;
    end else if (bus.load) begin
      r_state <= bus.seed_in;
    end else if (w_accept) begin
      r_state <= w_state_nxt;
    end
  end

  // Output register: refilled on accept, emptied on a drain without refill.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_out_bits;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

`ifdef LFSR_SCR_WORDCNT_EN
  logic [31:0] r_word_cnt;

  // Accepted-word counter; a seed load restarts the count, wraps naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_word_cnt <= '0;
    end else if (bus.load) begin
      r_word_cnt <= '0;
    end else if (w_accept) begin
      r_word_cnt <= r_word_cnt + 32'd1;
    end
  end

  assign word_cnt = r_word_cnt;
`endif

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.state_out = r_state;

endmodule
